// File: rtl/dm_port_arbiter.sv
// Round-robin arbiter/sequencer giving two masters one-at-a-time access to the data-memory port.
// Optional macro DM_ARB_ALIGN_CHECK_EN: reject misaligned or illegal byte-enable commands at grant.
module dm_port_arbiter #(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [BE_W-1:0]   be0,
  output logic              done0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [BE_W-1:0]   be1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_byteen,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [BE_W-1:0]   cmd_be_q, cmd_be_d;
  logic              cmd_id_q, cmd_id_d;
  logic              cmd_bad_q, cmd_bad_d;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] rdata_q [2];
  logic [DATA_W-1:0] rdata_d [2];

  logic [1:0]        req_v;
  logic [ADDR_W-1:0] addr_v  [2];
  logic [DATA_W-1:0] wdata_v [2];
  logic [BE_W-1:0]   be_v    [2];
  logic [1:0]        done_v;
  logic              grant_id;
  logic              grant_bad;

  assign req_v      = {req1, req0};
  assign addr_v[0]  = addr0;
  assign addr_v[1]  = addr1;
  assign wdata_v[0] = wdata0;
  assign wdata_v[1] = wdata1;
  assign be_v[0]    = be0;
  assign be_v[1]    = be1;

  // Under contention the requester that did not win last time goes next.
  always_comb begin
    grant_id = req_v[1];
    if (req_v == 2'b11) begin
      grant_id = ~last_grant_q;
    end
  end

`ifdef DM_ARB_ALIGN_CHECK_EN
  logic [BE_W-1:0] sel_be;
  logic [1:0]      sel_lsb;

  always_comb begin
    sel_be    = be_v[grant_id];
    sel_lsb   = addr_v[grant_id][1:0];
    grant_bad = 1'b0;
    case (sel_be)
      BE_W'(4'b0000), BE_W'(4'b0001), BE_W'(4'b0010),
      BE_W'(4'b0100), BE_W'(4'b1000): grant_bad = 1'b0;
      BE_W'(4'b0011), BE_W'(4'b1100): grant_bad = sel_lsb[0];
      BE_W'(4'b1111):                 grant_bad = (sel_lsb != 2'b00);
      default:                        grant_bad = 1'b1;
    endcase
  end
`else
  assign grant_bad = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    cmd_be_d     = cmd_be_q;
    cmd_id_d     = cmd_id_q;
    cmd_bad_d    = cmd_bad_q;
    last_grant_d = last_grant_q;
    rdata_d[0]   = rdata_q[0];
    rdata_d[1]   = rdata_q[1];
    case (state_q)
      ST_IDLE: begin
        if (req_v != 2'b00) begin
          cmd_addr_d   = addr_v[grant_id];
          cmd_wdata_d  = wdata_v[grant_id];
          cmd_be_d     = be_v[grant_id];
          cmd_id_d     = grant_id;
          cmd_bad_d    = grant_bad;
          last_grant_d = grant_id;
          state_d      = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Read data is captured on writes too; a rejected command returns zero.
        rdata_d[cmd_id_q] = cmd_bad_q ? '0 : mem_rdata;
        state_d           = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      cmd_be_q     <= '0;
      cmd_id_q     <= 1'b0;
      cmd_bad_q    <= 1'b0;
      last_grant_q <= 1'b1;
      rdata_q[0]   <= '0;
      rdata_q[1]   <= '0;
    end else begin
      state_q      <= state_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      cmd_be_q     <= cmd_be_d;
      cmd_id_q     <= cmd_id_d;
      cmd_bad_q    <= cmd_bad_d;
      last_grant_q <= last_grant_d;
      rdata_q[0]   <= rdata_d[0];
      rdata_q[1]   <= rdata_d[1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_done
      assign done_v[gi] = (state_q == ST_DONE) && (cmd_id_q == 1'(gi));
    end
  endgenerate

  assign done0  = done_v[0];
  assign done1  = done_v[1];
  assign rdata0 = rdata_q[0];
  assign rdata1 = rdata_q[1];
  assign busy   = (state_q != ST_IDLE);
  assign err    = (state_q == ST_DONE) && cmd_bad_q;

  // Byte enables are combinational from state so an async reset kills a pending write at once.
  assign mem_addr   = cmd_addr_q;
  assign mem_wdata  = cmd_wdata_q;
  assign mem_byteen = ((state_q == ST_BUSY) && !cmd_bad_q) ? cmd_be_q : '0;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter: directed vector table, corner sequences, random vs transaction model.
module tb_dm_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [3:0]  be0, be1;
  logic        done0, done1, busy, err;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_byteen;

  int total = 0;
  int bad   = 0;

  // Word-addressed memory model; the bench preloads it through a private write port.
  logic [31:0] mem [256];
  int          write_cnt = 0;
  logic        clr_en = 1'b0;
  logic        pl_en  = 1'b0;
  logic [7:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;

  always #5 clk = ~clk;

  dm_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .be0(be0), .done0(done0), .rdata0(rdata0),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .be1(be1), .done1(done1), .rdata1(rdata1),
    .busy(busy), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byteen(mem_byteen), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] w, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  function automatic bit is_bad(input logic [3:0] be, input logic [31:0] a);
    case (be)
      4'h0, 4'h1, 4'h2, 4'h4, 4'h8: return 1'b0;
      4'h3, 4'hC:                   return a[0];
      4'hF:                         return (a[1:0] != 2'b00);
      default:                      return 1'b1;
    endcase
  endfunction

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (clr_en) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (pl_en) begin
      mem[pl_idx] <= pl_data;
    end else if (mem_byteen != 4'h0) begin
      mem[mem_addr[9:2]] <= merge(mem[mem_addr[9:2]], mem_wdata, mem_byteen);
      write_cnt <= write_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] data);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  typedef struct {
    bit          id;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [31:0] exp_word;
    bit          exp_err;
    int          exp_writes;
  } vec_t;

  vec_t tbl [10];

  // One single-requester transaction from IDLE; checks latency, single-cycle done, data and memory.
  task automatic do_txn(input vec_t v, input string tag);
    int          w0;
    int          cyc;
    logic [31:0] rd;
    logic        e;
    w0  = write_cnt;
    cyc = 0;
    rd  = '0;
    e   = 1'b0;
    if (v.id == 1'b0) begin req0 = 1'b1; addr0 = v.addr; wdata0 = v.wdata; be0 = v.be; end
    else              begin req1 = 1'b1; addr1 = v.addr; wdata1 = v.wdata; be1 = v.be; end
    for (int c = 1; c <= 8 && cyc == 0; c++) begin
      @(posedge clk); #1;
      if (c == 1) chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_other_done"}, 32'(v.id ? done0 : done1), 32'd0);
      if (v.id ? done1 : done0) begin
        cyc = c;
        rd  = v.id ? rdata1 : rdata0;
        e   = err;
        req0 = 1'b0; req1 = 1'b0;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk({tag, "_latency"}, 32'(cyc), 32'd2);
    chk({tag, "_rdata"}, rd, v.exp_rd);
    chk({tag, "_err"}, 32'(e), 32'(v.exp_err));
    @(posedge clk); #1;
    chk({tag, "_done_width"}, 32'(v.id ? done1 : done0), 32'd0);
    chk({tag, "_word"}, mem[v.addr[9:2]], v.exp_word);
    chk({tag, "_writes"}, 32'(write_cnt - w0), 32'(v.exp_writes));
    $display("txn %s id=%0d be=%h addr=%h wdata=%h rdata=%h err=%0d", tag, v.id, v.be, v.addr, v.wdata, rd, e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, last_cyc, ndone, d1, d2, w0;
    logic [31:0] exp_rd;
    bit          act [2];
    logic [31:0] ra [2];
    logic [31:0] rw [2];
    logic [3:0]  rb [2];
    logic [31:0] erd [2];
    logic [31:0] exp_mem [256];
    logic [3:0]  legal [8];
    int          ph;
    bit          mlast, mwin, merr;
    logic [31:0] mrd, old;

    legal = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    reset = 1'b0;
    req0 = 1'b0; addr0 = '0; wdata0 = '0; be0 = '0;
    req1 = 1'b0; addr1 = '0; wdata1 = '0; be1 = '0;
    clr_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clr_en = 1'b0;

    // Reset state
    chk("rst_done0", 32'(done0), 32'd0);
    chk("rst_done1", 32'(done1), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_byteen", 32'(mem_byteen), 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Reset during BUSY drops the write and the done pulse
    w0 = write_cnt;
    req0 = 1'b1; addr0 = 32'h10; wdata0 = 32'hDEADBEEF; be0 = 4'hF;
    @(posedge clk); #1;
    chk("rmid_busy_byteen", 32'(mem_byteen), 32'hF);
    reset = 1'b0;
    #1;
    chk("rmid_byteen_drop", 32'(mem_byteen), 32'd0);
    chk("rmid_busy_drop", 32'(busy), 32'd0);
    req0 = 1'b0;
    @(posedge clk); #1;
    chk("rmid_no_done_a", 32'(done0), 32'd0);
    @(posedge clk); #1;
    chk("rmid_no_done_b", 32'(done0), 32'd0);
    reset = 1'b1;
    chk("rmid_word", mem[4], 32'd0);
    chk("rmid_writes", 32'(write_cnt - w0), 32'd0);
    $display("txn reset_mid id=0 be=f addr=00000010 dropped");

    // Contention: strict alternation starting with requester 0, done every 3 cycles
    preload(8'd64, 32'hA0A0A0A0);
    preload(8'd65, 32'hB1B1B1B1);
    req0 = 1'b1; addr0 = 32'h100; be0 = 4'h0; wdata0 = '0;
    req1 = 1'b1; addr1 = 32'h104; be1 = 4'h0; wdata1 = '0;
    n = 0; last_cyc = 0;
    for (int c = 1; c <= 40 && n < 6; c++) begin
      @(posedge clk); #1;
      if (done0 || done1) begin
        chk("cont_both_done", 32'(done0 & done1), 32'd0);
        chk("cont_winner", 32'(done1), 32'(n % 2));
        chk("cont_spacing", 32'(c - last_cyc), (n == 0) ? 32'd2 : 32'd3);
        exp_rd = (n % 2 == 1) ? 32'hB1B1B1B1 : 32'hA0A0A0A0;
        chk("cont_rdata", done1 ? rdata1 : rdata0, exp_rd);
        $display("txn contention n=%0d id=%0d cycle=%0d", n, done1, c);
        last_cyc = c;
        n++;
        if (n == 6) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("cont_count", 32'(n), 32'd6);
    @(posedge clk); #1;

    // Directed vector table
    tbl[0] = '{1'b0, 4'hF, 32'h10, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 1'b0, 1};
    tbl[1] = '{1'b0, 4'h0, 32'h10, 32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 0};
    tbl[2] = '{1'b1, 4'hF, 32'h10, 32'h11223344, 32'hDEADBEEF, 32'h11223344, 1'b0, 1};
    tbl[3] = '{1'b1, 4'h4, 32'h12, 32'h00AB0000, 32'h11223344, 32'h11AB3344, 1'b0, 1};
    tbl[4] = '{1'b0, 4'h0, 32'h12, 32'h00000000, 32'h11AB3344, 32'h11AB3344, 1'b0, 0};
`ifdef DM_ARB_ALIGN_CHECK_EN
    tbl[5] = '{1'b0, 4'hF, 32'h13, 32'hCAFEF00D, 32'h00000000, 32'h11AB3344, 1'b1, 0};
`else
    tbl[5] = '{1'b0, 4'hF, 32'h13, 32'hCAFEF00D, 32'h11AB3344, 32'hCAFEF00D, 1'b0, 1};
`endif
    tbl[6] = '{1'b1, 4'h1, 32'h20, 32'h000000EE, 32'h00000000, 32'h000000EE, 1'b0, 1};
    tbl[7] = '{1'b0, 4'h8, 32'h23, 32'h77000000, 32'h000000EE, 32'h770000EE, 1'b0, 1};
    tbl[8] = '{1'b1, 4'h3, 32'h20, 32'h0000BEEF, 32'h770000EE, 32'h7700BEEF, 1'b0, 1};
`ifdef DM_ARB_ALIGN_CHECK_EN
    tbl[9] = '{1'b1, 4'h6, 32'h21, 32'h00555500, 32'h00000000, 32'h7700BEEF, 1'b1, 0};
`else
    tbl[9] = '{1'b1, 4'h6, 32'h21, 32'h00555500, 32'h7700BEEF, 32'h775555EF, 1'b0, 1};
`endif
    for (int i = 0; i < 10; i++) do_txn(tbl[i], $sformatf("vec%0d", i));

    // Stale request: req0 held one cycle past done runs the write a second time
    w0 = write_cnt;
    req0 = 1'b1; addr0 = 32'h30; wdata0 = 32'h12345678; be0 = 4'hF;
    ndone = 0; d1 = 0; d2 = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (done0) begin
        ndone++;
        if (ndone == 1) d1 = c;
        if (ndone == 2) d2 = c;
      end
      if (ndone == 1 && c == d1 + 2) req0 = 1'b0;
    end
    req0 = 1'b0;
    chk("stale_dones", 32'(ndone), 32'd2);
    chk("stale_gap", 32'(d2 - d1), 32'd3);
    chk("stale_writes", 32'(write_cnt - w0), 32'd2);
    chk("stale_word", mem[12], 32'h12345678);
    $display("txn stale id=0 be=f addr=00000030 dones=%0d", ndone);

    // Random traffic against a transaction-level model
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 256; i++) exp_mem[i] = mem[i];
    act = '{1'b0, 1'b0};
    ra = '{32'd0, 32'd0}; rw = '{32'd0, 32'd0}; rb = '{4'h0, 4'h0};
    erd = '{32'd0, 32'd0};
    ph = 0; mlast = 1'b1; mwin = 1'b0; merr = 1'b0; mrd = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (act[i] && ph == 2 && mwin == 1'(i)) begin
          act[i] = 1'b0;
        end else if (!act[i] && cyc < 1500 && $urandom_range(0, 2) == 0) begin
          act[i] = 1'b1;
          ra[i]  = 32'($urandom_range(0, 63));
          rw[i]  = $urandom;
          rb[i]  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : legal[$urandom_range(0, 7)];
        end
      end
      req0 = act[0]; addr0 = ra[0]; wdata0 = rw[0]; be0 = rb[0];
      req1 = act[1]; addr1 = ra[1]; wdata1 = rw[1]; be1 = rb[1];
      if (cyc >= 1500 && !act[0] && !act[1] && ph == 0) break;
      if (ph == 0) begin
        if (act[0] || act[1]) begin
          mwin  = (act[0] && act[1]) ? !mlast : act[1];
          mlast = mwin;
          old   = exp_mem[ra[mwin][9:2]];
`ifdef DM_ARB_ALIGN_CHECK_EN
          merr = is_bad(rb[mwin], ra[mwin]);
`else
          merr = 1'b0;
`endif
          mrd = merr ? 32'd0 : old;
          if (!merr && rb[mwin] != 4'h0) exp_mem[ra[mwin][9:2]] = merge(old, rw[mwin], rb[mwin]);
          ph = 1;
        end
      end else if (ph == 1) begin
        ph = 2;
      end else begin
        ph = 0;
      end
      @(posedge clk); #1;
      if (ph == 2) begin
        erd[mwin] = mrd;
        $display("txn rnd id=%0d be=%h addr=%h rdata=%h err=%0d", mwin, rb[mwin], ra[mwin], mrd, merr);
      end
      chk("rnd_done0", 32'(done0), 32'(ph == 2 && mwin == 1'b0));
      chk("rnd_done1", 32'(done1), 32'(ph == 2 && mwin == 1'b1));
      chk("rnd_busy", 32'(busy), 32'(ph != 0));
      chk("rnd_err", 32'(err), 32'(ph == 2 && merr));
      chk("rnd_rdata0", rdata0, erd[0]);
      chk("rnd_rdata1", rdata1, erd[1]);
    end
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
    chk("rnd_idle_end", 32'(busy), 32'd0);
    for (int i = 0; i < 16; i++) chk($sformatf("rnd_mem%0d", i), mem[i], exp_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
